dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port 128x32 data memory between two requesters: port 0 (core load/store unit) and port 1 (aux: debug/DMA loader).
- Sits between the requesters and the data memory; it is the only block that drives the memory's write_en, read_en, address and data_in.
- Each port uses a req/ack handshake with round-robin arbitration.
- Memory read_en and write_en are never asserted together.

Parameters:
- ADDR_W, 7, memory word-address width.
- DATA_W, 32, data width.
- AUX_BASE, 64, lowest address port 1 may write; used only with the optional feature.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- p0_req  in  1  port 0 request, held until ack.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  ADDR_W  port 0 address.
- p0_wdata  in  DATA_W  port 0 write data.
- p0_ack  out  1  port 0 one-cycle completion pulse.
- p0_rdata  out  DATA_W  port 0 read data, valid with p0_ack.
- p1_req, p1_we, p1_addr, p1_wdata, p1_ack, p1_rdata: same as port 0, for port 1.
- p1_err  out  1  port 1 rejected access, pulses with p1_ack (optional feature only; tied 0 otherwise).
- mem_write_en  out  1  to memory write_en.
- mem_read_en  out  1  to memory read_en.
- mem_address  out  ADDR_W  to memory address.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_data_out  in  DATA_W  from memory (combinational read).

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, last_grant=1, latched fields=0.
  - All acks, err, mem_write_en and mem_read_en = 0; rdata regs=0.
  - mem_address and mem_data_in are driven from the latched fields, so they are also 0.
- FSM states: IDLE, SERVE, ACK.
- IDLE:
  - On an edge with any req high, pick the winner, latch its we/addr/wdata and grant, set last_grant=winner, go to SERVE.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only one req high: that port wins.
  - Both high: the port != last_grant wins (strict alternation under contention). First tie after reset goes to port 0.
- SERVE (exactly one cycle):
  - Write: mem_write_en=1, mem_read_en=0. Memory commits at the closing edge.
  - Read: mem_read_en=1, mem_write_en=0. mem_data_out is captured into the granted port's rdata reg at the closing edge.
  - mem_address and mem_data_in come from the latched fields only.
  - Next state is ACK.
- ACK (one cycle):
  - Granted port's ack=1. Its rdata holds the captured word; write-ack rdata is unchanged.
  - Arbitration runs as in IDLE, but the just-acked port's req is masked for this edge, since its requester drops req after seeing ack.
  - Another pending req goes straight to SERVE; otherwise go to IDLE.
- Latency: req seen at edge N → SERVE in cycle N+1 → ack in cycle N+2. Back-to-back throughput is one access per 2 cycles under contention, 3 cycles for the same port.
- rdata regs hold their value until the next read on that port.
- Outside SERVE, mem_write_en = mem_read_en = 0.
- Requester rules:
  - Fields must be stable only at the edge req is first seen; they are latched there.
  - Dropping req before ack has no effect: the latched access completes and ack still pulses.
- Reset mid-SERVE:
  - mem_write_en falls asynchronously, so no write occurs unless the clk edge precedes reset.
  - No ack is issued for the aborted access.
- Port numbering is fixed; no port has priority beyond the round-robin.

Optional Feature:
- Macro: DMEM_ARB_AUX_PROTECT_EN.
- Defined:
  - A port 1 write with addr < AUX_BASE still goes through SERVE, but mem_write_en stays 0 (no memory change).
  - The ACK cycle asserts p1_ack and p1_err together.
  - Port 1 reads and all port 0 accesses are unrestricted.
- Not defined: p1_err is tied 0 and port 1 writes any address.

Test Plan:
- Reset, then p0 write addr 5 data 0xDEADBEEF → mem_write_en=1 for exactly one cycle with mem_address=5; p0_ack 2 cycles after req; no mem_read_en overlap.
- p0 read addr 5 after that write → p0_rdata=0xDEADBEEF while p0_ack=1; mem_read_en high one cycle.
- p0 and p1 raise req on the same edge (p0 read addr 1, p1 write addr 2 = 0x11) → p0 served first, then p1 SERVE directly from ACK; second pair of simultaneous reqs → p1 first.
- Both ports hold req continuously for 8 accesses → acks alternate p0,p1,p0,…; each port gets 4.
- Assert rst_n=0 during a SERVE write to addr 9 (before the clock edge) → memory word 9 unchanged, no ack, all outputs 0; normal operation resumes after release.
- With DMEM_ARB_AUX_PROTECT_EN: p1 write addr 10 = 0x55 → p1_ack=p1_err=1, mem_write_en never high, word 10 unchanged; p1 write addr 70 → written, err=0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between the core (port 0) and an aux requester (port 1).
// Optional macro DMEM_ARB_AUX_PROTECT_EN blocks port 1 writes below AUX_BASE and flags them on p1_err.
`timescale 1ns/1ps
module dmem_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 32,
  parameter int AUX_BASE = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              p1_err,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  typedef enum logic [1:0] {IDLE, SERVE, ACK} state_t;

  localparam logic [ADDR_W-1:0] AUX_BASE_A = ADDR_W'(AUX_BASE);
`ifdef DMEM_ARB_AUX_PROTECT_EN
  localparam bit PROTECT = 1'b1;
`else
  localparam bit PROTECT = 1'b0;
`endif

  state_t              state_reg, state_next;
  logic                last_grant_reg, last_grant_next;
  logic                grant_reg, grant_next;
  logic                we_reg, we_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [DATA_W-1:0]   wdata_reg, wdata_next;
  logic [DATA_W-1:0]   p0_rdata_reg, p1_rdata_reg;

  logic req0, req1, winner, blocked;

  // The port acked this cycle drops its req after seeing ack, so ignore it for this edge.
  assign req0   = p0_req && !(state_reg == ACK && grant_reg == 1'b0);
  assign req1   = p1_req && !(state_reg == ACK && grant_reg == 1'b1);
  assign winner = (req0 && req1) ? ~last_grant_reg : req1;

  assign blocked = PROTECT && grant_reg && we_reg && (addr_reg < AUX_BASE_A);

  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    grant_next      = grant_reg;
    we_next         = we_reg;
    addr_next       = addr_reg;
    wdata_next      = wdata_reg;
    case (state_reg)
      IDLE, ACK: begin
        if (req0 || req1) begin
          state_next      = SERVE;
          grant_next      = winner;
          last_grant_next = winner;
          we_next         = winner ? p1_we    : p0_we;
          addr_next       = winner ? p1_addr  : p0_addr;
          wdata_next      = winner ? p1_wdata : p0_wdata;
        end else begin
          state_next = IDLE;
        end
      end
      SERVE:   state_next = ACK;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;
      grant_reg      <= 1'b0;
      we_reg         <= 1'b0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      p0_rdata_reg   <= '0;
      p1_rdata_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
      grant_reg      <= grant_next;
      we_reg         <= we_next;
      addr_reg       <= addr_next;
      wdata_reg      <= wdata_next;
      if (state_reg == SERVE && !we_reg) begin
        if (grant_reg) p1_rdata_reg <= mem_data_out;
        else           p0_rdata_reg <= mem_data_out;
      end
    end
  end

  // Enables decode straight from the state register so reset drops them asynchronously.
  assign mem_write_en = (state_reg == SERVE) && we_reg && !blocked;
  assign mem_read_en  = (state_reg == SERVE) && !we_reg;
  assign mem_address  = addr_reg;
  assign mem_data_in  = wdata_reg;

  assign p0_ack   = (state_reg == ACK) && !grant_reg;
  assign p1_ack   = (state_reg == ACK) && grant_reg;
  assign p0_rdata = p0_rdata_reg;
  assign p1_rdata = p1_rdata_reg;

`ifdef DMEM_ARB_AUX_PROTECT_EN
  assign p1_err = p1_ack && blocked;
`else
  assign p1_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 128x32 memory (combinational read, clocked write).
`timescale 1ns/1ps
module tb_dmem_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p0_wdata, p1_wdata;
  logic          p0_ack, p1_ack, p1_err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_write_en, mem_read_en;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data_in, mem_data_out;

  logic [DW-1:0] mem [128];

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .AUX_BASE(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  assign mem_data_out = mem[mem_address];

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_address] = mem_data_in;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acks, c0, c1;
    for (int i = 0; i < 128; i++) mem[i] = 32'h1000_0000 + i;
    rst_n = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    tick; tick;

    // Reset state
    chk("rst_p0_ack", p0_ack, 0);
    chk("rst_p1_ack", p1_ack, 0);
    chk("rst_p1_err", p1_err, 0);
    chk("rst_we", mem_write_en, 0);
    chk("rst_re", mem_read_en, 0);
    chk("rst_addr", mem_address, 0);
    chk("rst_din", mem_data_in, 0);
    chk("rst_p0_rdata", p0_rdata, 0);
    chk("rst_p1_rdata", p1_rdata, 0);
    #2 rst_n = 1'b1;
    tick;

    // p0 write 5 = DEADBEEF
    p0_req = 1; p0_we = 1; p0_addr = 5; p0_wdata = 32'hDEADBEEF;
    tick;
    chk("b_serve_we", mem_write_en, 1);
    chk("b_serve_re", mem_read_en, 0);
    chk("b_serve_addr", mem_address, 5);
    chk("b_serve_din", mem_data_in, 32'hDEADBEEF);
    chk("b_serve_noack", p0_ack, 0);
    tick;
    chk("b_ack", p0_ack, 1);
    chk("b_ack_we", mem_write_en, 0);
    chk("b_mem5", mem[5], 32'hDEADBEEF);
    p0_req = 0;
    tick;
    chk("b_idle_ack", p0_ack, 0);
    chk("b_idle_we", mem_write_en, 0);

    // p0 read 5
    p0_req = 1; p0_we = 0; p0_addr = 5;
    tick;
    chk("c_serve_re", mem_read_en, 1);
    chk("c_serve_we", mem_write_en, 0);
    chk("c_serve_addr", mem_address, 5);
    tick;
    chk("c_ack", p0_ack, 1);
    chk("c_rdata", p0_rdata, 32'hDEADBEEF);
    chk("c_ack_re", mem_read_en, 0);
    p0_req = 0;
    tick;

    // Tie with last_grant=0: p1 (write 3 = 0x22) first, then p0 reads it back
    p0_req = 1; p0_we = 0; p0_addr = 3;
    p1_req = 1; p1_we = 1; p1_addr = 3; p1_wdata = 32'h22;
    tick;
    chk("d_serve1_we", mem_write_en, 1);
    chk("d_serve1_addr", mem_address, 3);
    chk("d_serve1_din", mem_data_in, 32'h22);
    tick;
    chk("d_p1_ack", p1_ack, 1);
    chk("d_p0_noack", p0_ack, 0);
    chk("d_mem3", mem[3], 32'h22);
    p1_req = 0;
    tick;
    chk("d_serve2_re", mem_read_en, 1);
    chk("d_serve2_p1ack", p1_ack, 0);
    tick;
    chk("d_p0_ack", p0_ack, 1);
    chk("d_p0_rdata", p0_rdata, 32'h22);
    chk("d_p1_rdata", p1_rdata, 0);
    p0_req = 0;
    tick;

    // Reset during a SERVE write to 9
    p0_req = 1; p0_we = 1; p0_addr = 9; p0_wdata = 32'h0BAD;
    tick;
    chk("e_serve_we", mem_write_en, 1);
    rst_n = 1'b0;
    #1;
    chk("e_abort_we", mem_write_en, 0);
    chk("e_abort_addr", mem_address, 0);
    chk("e_abort_din", mem_data_in, 0);
    chk("e_abort_rdata", p0_rdata, 0);
    chk("e_abort_ack", p0_ack, 0);
    p0_req = 0;
    tick;
    chk("e_mem9", mem[9], 32'h1000_0009);
    chk("e_noack", p0_ack, 0);
    rst_n = 1'b1;
    tick;

    // First tie after reset goes to p0 (read 1), then p1 (write 2 = 0x11) straight from ACK
    p0_req = 1; p0_we = 0; p0_addr = 1;
    p1_req = 1; p1_we = 1; p1_addr = 2; p1_wdata = 32'h11;
    tick;
    chk("e2_serve_re", mem_read_en, 1);
    chk("e2_serve_addr", mem_address, 1);
    tick;
    chk("e2_p0_ack", p0_ack, 1);
    chk("e2_p0_rdata", p0_rdata, 32'h1000_0001);
    chk("e2_p1_noack", p1_ack, 0);
    p0_req = 0;
    tick;
    chk("e2_serve_we", mem_write_en, 1);
    chk("e2_serve2_addr", mem_address, 2);
    chk("e2_p0_ack_off", p0_ack, 0);
    tick;
    chk("e2_p1_ack", p1_ack, 1);
    chk("e2_mem2", mem[2], 32'h11);
    p1_req = 0;
    tick;

    // Sustained contention: 8 accesses alternating p0,p1,...
    p0_req = 1; p0_we = 0; p0_addr = 9;
    p1_req = 1; p1_we = 0; p1_addr = 2;
    acks = 0; c0 = 0; c1 = 0;
    for (int cyc = 0; cyc < 24 && acks < 8; cyc++) begin
      tick;
      chk("f_excl", mem_read_en & mem_write_en, 0);
      if (p0_ack || p1_ack) begin
        chk("f_order", p1_ack, acks % 2);
        chk("f_both", p0_ack & p1_ack, 0);
        if (p0_ack) begin
          c0++;
          chk("f_rd0", p0_rdata, 32'h1000_0009);
        end else begin
          c1++;
          chk("f_rd1", p1_rdata, 32'h11);
        end
        acks++;
        if (acks == 8) begin
          p0_req = 0; p1_req = 0;
        end
      end
    end
    chk("f_count0", c0, 4);
    chk("f_count1", c1, 4);
    tick;
    chk("f_idle", p0_ack | p1_ack, 0);

`ifdef DMEM_ARB_AUX_PROTECT_EN
    p1_req = 1; p1_we = 1; p1_addr = 10; p1_wdata = 32'h55;
    tick;
    chk("g_blk_we", mem_write_en, 0);
    tick;
    chk("g_blk_ack", p1_ack, 1);
    chk("g_blk_err", p1_err, 1);
    chk("g_mem10", mem[10], 32'h1000_000A);
    p1_req = 0;
    tick;
    p1_req = 1; p1_we = 1; p1_addr = 70; p1_wdata = 32'h77;
    tick;
    chk("g_ok_we", mem_write_en, 1);
    tick;
    chk("g_ok_ack", p1_ack, 1);
    chk("g_ok_err", p1_err, 0);
    chk("g_mem70", mem[70], 32'h77);
    p1_req = 0;
    tick;
`else
    p1_req = 1; p1_we = 1; p1_addr = 10; p1_wdata = 32'h55;
    tick;
    chk("g_we", mem_write_en, 1);
    tick;
    chk("g_ack", p1_ack, 1);
    chk("g_err", p1_err, 0);
    chk("g_mem10", mem[10], 32'h55);
    p1_req = 0;
    tick;
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
